// File: rtl/axis_pkg.sv
// Shared AXI-Stream definitions for the 1024->512 width down-converter and
// its neighbouring stages: beat types, width constants and keep helpers.
package axis_pkg;

    localparam int IN_BYTES  = 128;
    localparam int OUT_BYTES = 64;
    localparam int RATIO     = IN_BYTES / OUT_BYTES;
    localparam int IDX_W     = (RATIO > 1) ? $clog2(RATIO) : 1;

    typedef struct packed {
        logic [8*IN_BYTES-1:0] data;
        logic [IN_BYTES-1:0]   keep;
        logic                  last;
    } in_beat_t;

    typedef struct packed {
        logic [8*OUT_BYTES-1:0] data;
        logic [OUT_BYTES-1:0]   keep;
        logic                   last;
    } out_beat_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_DRAIN = 1'b1
    } dsz_state_t;

    // Highest output slice holding any enabled byte; 0 when keep is all-zero.
    function automatic logic [IDX_W-1:0] keep_last_slice(input logic [IN_BYTES-1:0] keep);
        logic [IDX_W-1:0] li;
        li = '0;
        for (int k = 0; k < RATIO; k++) begin
            if (|keep[k*OUT_BYTES +: OUT_BYTES]) begin
                li = IDX_W'(k);
            end
        end
        return li;
    endfunction

endpackage

// File: rtl/axis_downsize_1024_to_512_enc.sv
// Priority encoder over per-slice "any byte enabled" flags: reports the
// highest non-empty slice and whether the whole beat is empty.
module keep_slice_encoder #(
    parameter int RATIO     = 2,
    parameter int OUT_BYTES = 64,
    parameter int IDX_W     = 1
) (
    input  logic [RATIO*OUT_BYTES-1:0] keep,
    output logic [IDX_W-1:0]           last_idx,
    output logic                       all_zero
);

    always_comb begin
        last_idx = '0;
        all_zero = 1'b1;
        for (int k = 0; k < RATIO; k++) begin
            if (|keep[k*OUT_BYTES +: OUT_BYTES]) begin
                last_idx = IDX_W'(k);
                all_zero = 1'b0;
            end
        end
    end

endmodule

// File: rtl/axis_downsize_1024_to_512.sv
// AXI-Stream width down-converter: one buffered wide beat is replayed as
// OUT_BYTES slices, LSB first, stopping after the last non-empty slice.
module axis_downsize_1024_to_512
    import axis_pkg::dsz_state_t;
    import axis_pkg::ST_EMPTY;
    import axis_pkg::ST_DRAIN;
#(
    parameter int IN_BYTES  = 128,
    parameter int OUT_BYTES = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [8*IN_BYTES-1:0]  in_data,
    input  logic [IN_BYTES-1:0]    in_keep,
    input  logic                   in_valid,
    input  logic                   in_last,
    output logic                   in_ready,
    output logic [8*OUT_BYTES-1:0] out_data,
    output logic [OUT_BYTES-1:0]   out_keep,
    output logic                   out_valid,
    output logic                   out_last,
    input  logic                   out_ready
);

    localparam int RATIO = IN_BYTES / OUT_BYTES;
    localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int OUT_W = 8 * OUT_BYTES;

    dsz_state_t             state, state_nxt;
    logic [8*IN_BYTES-1:0]  buf_data;
    logic [IN_BYTES-1:0]    buf_keep;
    logic                   buf_last;
    logic [IDX_W-1:0]       idx;
    logic [IDX_W-1:0]       last_idx;
    logic [IDX_W-1:0]       enc_last_idx;
    logic                   enc_all_zero;
    logic                   full;
    logic                   at_last;
    logic                   accept;
    logic                   out_hs;

    keep_slice_encoder #(
        .RATIO     (RATIO),
        .OUT_BYTES (OUT_BYTES),
        .IDX_W     (IDX_W)
    ) u_enc (
        .keep     (in_keep),
        .last_idx (enc_last_idx),
        .all_zero (enc_all_zero)
    );

    assign full     = (state == ST_DRAIN);
    assign at_last  = (idx == last_idx);
    assign out_hs   = full && out_ready;
    // Accepting on the final slice handshake lets consecutive beats stream without a bubble.
    assign in_ready = rst_n && (!full || (out_ready && at_last));
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (accept) begin
            // An empty, non-final beat carries nothing and is simply dropped.
            state_nxt = (enc_all_zero && !in_last) ? ST_EMPTY : ST_DRAIN;
        end else if (out_hs && at_last) begin
            state_nxt = ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buf_data <= '0;
            buf_keep <= '0;
            buf_last <= 1'b0;
            idx      <= '0;
            last_idx <= '0;
        end else if (accept) begin
            buf_data <= in_data;
            buf_keep <= in_keep;
            buf_last <= in_last;
            idx      <= '0;
            last_idx <= enc_last_idx;
        end else if (out_hs && !at_last) begin
            idx <= idx + IDX_W'(1);
        end
    end

    always_comb begin
        out_valid = full;
        out_data  = '0;
        out_keep  = '0;
        out_last  = 1'b0;
        if (full) begin
            out_data = buf_data[int'(idx)*OUT_W +: OUT_W];
            out_keep = buf_keep[int'(idx)*OUT_BYTES +: OUT_BYTES];
            out_last = buf_last && at_last;
        end
    end

endmodule

// File: tb/tb_axis_downsize_1024_to_512.sv
// Self-checking bench for axis_downsize_1024_to_512: directed scenarios plus
// a randomized backpressure run against a queue-based reference model.
module tb_axis_downsize_1024_to_512;

    typedef struct packed {
        logic [511:0] d;
        logic [63:0]  k;
        logic         l;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1023:0] in_data;
    logic [127:0]  in_keep;
    logic          in_valid;
    logic          in_last;
    logic          in_ready;
    logic [511:0]  out_data;
    logic [63:0]   out_keep;
    logic          out_valid;
    logic          out_last;
    logic          out_ready;

    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];
    bit   ready_rand = 1'b0;

    logic         prev_stall = 1'b0;
    logic [511:0] prev_d;
    logic [63:0]  prev_k;
    logic         prev_l;

    axis_downsize_1024_to_512 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_keep   (in_keep),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (ready_rand) out_ready = ($urandom_range(0, 1) == 1);
    end

    function automatic logic [1023:0] rand_data();
        logic [1023:0] r;
        for (int i = 0; i < 32; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    function automatic logic [127:0] keep_n(input int n);
        logic [127:0] k;
        k = '0;
        for (int i = 0; i < n; i++) k[i] = 1'b1;
        return k;
    endfunction

    // Reference model: slices up to the highest non-empty one; empty final beat gives one keep=0 beat.
    function automatic void model_push(input logic [1023:0] d, input logic [127:0] k, input logic l);
        exp_t e;
        int   hi;
        hi = -1;
        for (int s = 0; s < 2; s++) if (k[s*64 +: 64] != 64'h0) hi = s;
        if (hi < 0) begin
            if (l) begin
                e.d = d[511:0]; e.k = 64'h0; e.l = 1'b1;
                sb.push_back(e);
            end
        end else begin
            for (int s = 0; s <= hi; s++) begin
                e.d = d[s*512 +: 512];
                e.k = k[s*64 +: 64];
                e.l = l && (s == hi);
                sb.push_back(e);
            end
        end
    endfunction

    // Scoreboard and AXI stability monitor.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                tests++;
                if (out_valid !== 1'b1 || out_data !== prev_d || out_keep !== prev_k || out_last !== prev_l) begin
                    fails++;
                    $display("FAIL stall_hold: valid=%b keep=%h last=%b, required valid=1 keep=%h last=%b held",
                             out_valid, out_keep, out_last, prev_k, prev_l);
                end
            end
            if (out_valid && !out_ready) begin
                tests++;
                if (in_ready !== 1'b0) begin
                    fails++;
                    $display("FAIL in_ready_stall: in_ready=%b, required 0", in_ready);
                end
            end
            if (out_valid && out_ready) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL sb_unexpected: keep=%h last=%b, required no beat", out_keep, out_last);
                end else begin
                    e = sb.pop_front();
                    if (out_data !== e.d || out_keep !== e.k || out_last !== e.l) begin
                        fails++;
                        $display("FAIL sb_beat: keep=%h last=%b data=%h, required keep=%h last=%b data=%h",
                                 out_keep, out_last, out_data, e.k, e.l, e.d);
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_d = out_data;
            prev_k = out_keep;
            prev_l = out_last;
        end
    end

    // Called just after a posedge; returns just after the accepting posedge.
    task automatic send_beat(input logic [1023:0] d, input logic [127:0] k, input logic l);
        int n;
        in_data = d; in_keep = k; in_last = l; in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 500) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            tests++; fails++;
            $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
        end else begin
            model_push(d, k, l);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d beats still expected, required 0", sb.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_keep = '0; in_data = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests += 5;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: %b, required 0", out_valid); end
        if (out_data !== '0) begin fails++; $display("FAIL rst_data: %h, required 0", out_data); end
        if (out_keep !== '0) begin fails++; $display("FAIL rst_keep: %h, required 0", out_keep); end
        if (out_last !== 1'b0) begin fails++; $display("FAIL rst_last: %b, required 0", out_last); end
        if (in_ready !== 1'b0) begin fails++; $display("FAIL rst_in_ready: %b, required 0", in_ready); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_full_beat();
        logic [1023:0] d;
        d = rand_data();
        out_ready = 1'b1;
        send_beat(d, {128{1'b1}}, 1'b1);
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b1 || out_data !== d[511:0] || out_keep !== {64{1'b1}} || out_last !== 1'b0) begin
            fails++;
            $display("FAIL full_slice0: valid=%b keep=%h last=%b, required valid=1 keep=all-ones last=0 data=in[511:0]",
                     out_valid, out_keep, out_last);
        end
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b1 || out_data !== d[1023:512] || out_keep !== {64{1'b1}} || out_last !== 1'b1) begin
            fails++;
            $display("FAIL full_slice1: valid=%b keep=%h last=%b, required valid=1 keep=all-ones last=1 data=in[1023:512]",
                     out_valid, out_keep, out_last);
        end
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL full_idle: valid=%b, required 0", out_valid); end
        wait_drain();
    endtask

    task automatic test_partial();
        logic [1023:0] d;
        d = rand_data();
        out_ready = 1'b1;
        send_beat(d, keep_n(48), 1'b1);
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b1 || out_keep !== 64'h0000_FFFF_FFFF_FFFF || out_last !== 1'b1 ||
            out_data !== d[511:0] || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL partial: valid=%b keep=%h last=%b in_ready=%b, required 1 0000ffffffffffff 1 1",
                     out_valid, out_keep, out_last, in_ready);
        end
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL partial_idle: valid=%b, required 0", out_valid); end
        wait_drain();
    endtask

    task automatic test_back_to_back();
        logic [63:0] k_obs[4];
        logic        l_obs[4];
        logic        v_obs[4];
        logic        r_obs0;
        logic [63:0] k_exp[4];
        logic        l_exp[4];
        k_exp[0] = {64{1'b1}}; l_exp[0] = 1'b0;
        k_exp[1] = 64'h0000_0000_0000_FFFF; l_exp[1] = 1'b0;
        k_exp[2] = {64{1'b1}}; l_exp[2] = 1'b0;
        k_exp[3] = {64{1'b1}}; l_exp[3] = 1'b1;
        out_ready = 1'b1;
        send_beat(rand_data(), keep_n(80), 1'b0);
        fork
            send_beat(rand_data(), {128{1'b1}}, 1'b1);
            begin
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    v_obs[i] = out_valid; k_obs[i] = out_keep; l_obs[i] = out_last;
                    if (i == 0) r_obs0 = in_ready;
                end
            end
        join
        tests++;
        if (r_obs0 !== 1'b0) begin fails++; $display("FAIL b2b_in_ready_mid: %b, required 0", r_obs0); end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (v_obs[i] !== 1'b1 || k_obs[i] !== k_exp[i] || l_obs[i] !== l_exp[i]) begin
                fails++;
                $display("FAIL b2b_beat%0d: valid=%b keep=%h last=%b, required valid=1 keep=%h last=%b",
                         i, v_obs[i], k_obs[i], l_obs[i], k_exp[i], l_exp[i]);
            end
        end
        wait_drain();
    endtask

    task automatic test_zero_keep();
        out_ready = 1'b1;
        send_beat(rand_data(), '0, 1'b0);
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL zero_nolast: valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
        end
        @(posedge clk);
        #1;
        send_beat(rand_data(), '0, 1'b1);
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b1 || out_keep !== 64'h0 || out_last !== 1'b1) begin
            fails++;
            $display("FAIL zero_last: valid=%b keep=%h last=%b, required 1 0 1", out_valid, out_keep, out_last);
        end
        wait_drain();
    endtask

    task automatic test_backpressure();
        int nb;
        int n;
        ready_rand = 1'b1;
        for (int p = 0; p < 1000; p++) begin
            nb = $urandom_range(1, 3);
            for (int b = 0; b < nb; b++) begin
                if (b == nb - 1 || $urandom_range(0, 7) == 0) n = $urandom_range(0, 128);
                else n = 128;
                send_beat(rand_data(), keep_n(n), b == nb - 1);
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        wait_drain();
        ready_rand = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_reset_mid();
        logic [1023:0] d;
        out_ready = 1'b1;
        send_beat(rand_data(), {128{1'b1}}, 1'b1);
        rst_n = 1'b0;
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_keep !== 64'h0) begin
            fails++;
            $display("FAIL rst_mid: valid=%b in_ready=%b keep=%h, required 0 0 0", out_valid, in_ready, out_keep);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        d = rand_data();
        send_beat(d, keep_n(100), 1'b1);
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b1 || out_data !== d[511:0] || out_keep !== {64{1'b1}} || out_last !== 1'b0) begin
            fails++;
            $display("FAIL rst_fresh: valid=%b keep=%h last=%b, required 1 all-ones 0 with fresh data",
                     out_valid, out_keep, out_last);
        end
        wait_drain();
    endtask

    initial begin
        test_reset();
        test_full_beat();
        test_partial();
        test_back_to_back();
        test_zero_keep();
        test_backpressure();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
